// File: rtl/multicycle_ctrl.sv
// Instruction sequencer for the multi-cycle MIPS core: steps IF/ID/EX/MEM/WB,
// gates SRAM enables and IR/PC/write-back strobes, and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned IMEM_LAT = 1,
  parameter int unsigned DMEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        op_load,
  input  logic        op_store,
  output logic [4:0]  cur_state,
  output logic        inst_sram_en,
  output logic        ir_wen,
  output logic        pc_wen,
  output logic        data_sram_gate,
  output logic        wb_wen,
  output logic        retire,
  output logic [31:0] inst_cnt
);

  typedef enum logic [4:0] {
    S_IF  = 5'b00001,
    S_ID  = 5'b00010,
    S_EX  = 5'b00100,
    S_MEM = 5'b01000,
    S_WB  = 5'b10000
  } state_e;

  localparam logic [3:0] IMEM_LAST = 4'(IMEM_LAT - 1);
  localparam logic [3:0] DMEM_LAST = 4'(DMEM_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic        busy_q, busy_d;
  logic        load_q, load_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;

  always_comb begin
    state_d        = state_q;
    lat_d          = lat_q;
    busy_d         = busy_q;
    load_d         = load_q;
    cur_state      = state_q;
    inst_sram_en   = 1'b0;
    ir_wen         = 1'b0;
    pc_wen         = 1'b0;
    data_sram_gate = 1'b0;
    wb_wen         = 1'b0;
    retire         = 1'b0;

    case (state_q)
      S_IF: begin
        // An idle IF only starts a fetch when run is high; once busy it finishes regardless.
        if (busy_q || run) begin
          inst_sram_en = 1'b1;
          if (lat_q == IMEM_LAST) begin
            ir_wen  = 1'b1;
            pc_wen  = 1'b1;
            state_d = S_ID;
            lat_d   = '0;
            busy_d  = 1'b0;
          end else begin
            lat_d  = lat_q + 4'd1;
            busy_d = 1'b1;
          end
        end
      end
      S_ID: state_d = S_EX;
      S_EX: begin
        // Retire of a non-memory instruction falls on its EX cycle, so it follows op_* directly.
        load_d = op_load;
        if (op_load || op_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_IF;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        data_sram_gate = 1'b1;
        if (lat_q == DMEM_LAST) begin
          lat_d = '0;
          if (load_q) begin
            state_d = S_WB;
          end else begin
            state_d = S_IF;
            retire  = 1'b1;
          end
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      S_WB: begin
        wb_wen  = 1'b1;
        retire  = 1'b1;
        state_d = S_IF;
      end
      default: begin
        cur_state = S_IF;
        state_d   = S_IF;
        lat_d     = '0;
        busy_d    = 1'b0;
      end
    endcase

    inst_cnt_d = inst_cnt_q + 32'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IF;
      lat_q      <= '0;
      busy_q     <= 1'b0;
      load_q     <= 1'b0;
      inst_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      busy_q     <= busy_d;
      load_q     <= load_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

  assign inst_cnt = inst_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl; expected cycles are derived
// per instruction from its kind and the fetch/data latencies.
module tb_multicycle_ctrl;

  localparam int IL = 2;
  localparam int DL = 3;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1, run = 1'b0, op_load = 1'b0, op_store = 1'b0;

  logic [4:0]  cur_state, d1_cur_state;
  logic        inst_sram_en, ir_wen, pc_wen, data_sram_gate, wb_wen, retire;
  logic        d1_inst_sram_en, d1_ir_wen, d1_pc_wen, d1_data_sram_gate, d1_wb_wen, d1_retire;
  logic [31:0] inst_cnt, d1_inst_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_cnt = '0;

  multicycle_ctrl #(.IMEM_LAT(IL), .DMEM_LAT(DL)) u_dut (
    .clk(clk), .rst(rst), .run(run), .op_load(op_load), .op_store(op_store),
    .cur_state(cur_state), .inst_sram_en(inst_sram_en), .ir_wen(ir_wen),
    .pc_wen(pc_wen), .data_sram_gate(data_sram_gate), .wb_wen(wb_wen),
    .retire(retire), .inst_cnt(inst_cnt)
  );

  multicycle_ctrl #(.IMEM_LAT(1), .DMEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .run(run), .op_load(op_load), .op_store(op_store),
    .cur_state(d1_cur_state), .inst_sram_en(d1_inst_sram_en), .ir_wen(d1_ir_wen),
    .pc_wen(d1_pc_wen), .data_sram_gate(d1_data_sram_gate), .wb_wen(d1_wb_wen),
    .retire(d1_retire), .inst_cnt(d1_inst_cnt)
  );

  always #5 clk = ~clk;

  wire [42:0] act_main = {cur_state, inst_sram_en, ir_wen, pc_wen, data_sram_gate,
                          wb_wen, retire, inst_cnt};
  wire [42:0] act_d1   = {d1_cur_state, d1_inst_sram_en, d1_ir_wen, d1_pc_wen,
                          d1_data_sram_gate, d1_wb_wen, d1_retire, d1_inst_cnt};

  typedef struct {
    logic [42:0] exp;
    logic        ld;
    logic        st;
    logic        rn;
    bit          rst_after;
  } cyc_t;

  function automatic logic [42:0] mk(input logic [4:0] st, input logic ise, input logic ir,
                                     input logic pc, input logic gate, input logic wb,
                                     input logic ret, input logic [31:0] cnt);
    return {st, ise, ir, pc, gate, wb, ret, cnt};
  endfunction

  // run_mode: 0 run held high, 1 run random once the fetch has started, 2 run dropped from MEM on.
  task automatic run_instr(input string name, input int kind, input bit both,
                           input int run_mode, input int abort_mem);
    cyc_t seq[$];
    cyc_t c;
    logic [31:0] cnt = exp_cnt;
    for (int i = 0; i < IL; i++) begin
      c.exp = mk(5'b00001, 1'b1, i == IL-1, i == IL-1, 1'b0, 1'b0, 1'b0, cnt);
      c.ld = 1'($urandom); c.st = 1'($urandom);
      c.rn = (i == 0 || run_mode != 1) ? 1'b1 : 1'($urandom);
      c.rst_after = 1'b0;
      seq.push_back(c);
    end
    c.exp = mk(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
    c.ld = 1'($urandom); c.st = 1'($urandom);
    c.rn = (run_mode == 1) ? 1'($urandom) : 1'b1;
    seq.push_back(c);
    c.exp = mk(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, kind == K_ALU, cnt);
    c.ld = (kind == K_LOAD);
    c.st = (kind == K_STORE) || (kind == K_LOAD && both);
    c.rn = (run_mode == 1) ? 1'($urandom) : 1'b1;
    seq.push_back(c);
    if (kind == K_ALU) cnt++;
    if (kind != K_ALU) begin
      for (int j = 0; j < DL; j++) begin
        c.exp = mk(5'b01000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                   kind == K_STORE && j == DL-1, cnt);
        c.ld = 1'($urandom); c.st = 1'($urandom);
        c.rn = (run_mode == 0) ? 1'b1 : (run_mode == 2) ? 1'b0 : 1'($urandom);
        c.rst_after = (j == abort_mem);
        seq.push_back(c);
        c.rst_after = 1'b0;
      end
      if (kind == K_STORE) cnt++;
    end
    if (kind == K_LOAD) begin
      c.exp = mk(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, cnt);
      c.ld = 1'($urandom); c.st = 1'($urandom);
      c.rn = (run_mode == 0) ? 1'b1 : (run_mode == 2) ? 1'b0 : 1'($urandom);
      seq.push_back(c);
      cnt++;
    end

    foreach (seq[k]) begin
      op_load = seq[k].ld; op_store = seq[k].st; run = seq[k].rn;
      @(negedge clk);
      n_cmp++;
      if (act_main !== seq[k].exp) begin
        n_err++;
        $display("FAIL %s cyc%0d: got %h expected %h", name, k, act_main, seq[k].exp);
      end
      if (seq[k].rst_after) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        n_cmp++;
        if (act_main !== mk(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0)) begin
          n_err++;
          $display("FAIL %s after_rst: got %h expected %h", name, act_main,
                   mk(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
        end
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    exp_cnt = cnt;
  endtask

  task automatic idle(input string name, input int n);
    logic [42:0] e;
    run = 1'b0;
    for (int i = 0; i < n; i++) begin
      op_load = 1'($urandom); op_store = 1'($urandom);
      e = mk(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
      @(negedge clk);
      n_cmp++;
      if (act_main !== e) begin
        n_err++;
        $display("FAIL %s idle%0d: got %h expected %h", name, i, act_main, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [42:0] e;
    rst = 1'b1; run = 1'b0; op_load = 1'b0; op_store = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = '0;
    e = mk(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (act_main !== e) begin
        n_err++;
        $display("FAIL reset_main cyc%0d: got %h expected %h", i, act_main, e);
      end
      n_cmp++;
      if (act_d1 !== e) begin
        n_err++;
        $display("FAIL reset_d1 cyc%0d: got %h expected %h", i, act_d1, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_defaults();
    logic [42:0] e;
    run = 1'b1; op_load = 1'b0; op_store = 1'b0;
    for (int c = 0; c < 9; c++) begin
      e = mk(5'(1 << (c % 3)), c % 3 == 0, c % 3 == 0, c % 3 == 0, 1'b0, 1'b0,
             c % 3 == 2, 32'(c / 3));
      @(negedge clk);
      n_cmp++;
      if (act_d1 !== e) begin
        n_err++;
        $display("FAIL alu_defaults cyc%0d: got %h expected %h", c, act_d1, e);
      end
      @(posedge clk); #1;
    end
    run = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (d1_inst_cnt !== 32'd3) begin
      n_err++;
      $display("FAIL alu_defaults_cnt: got %0d expected 3", d1_inst_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    run_instr("load", K_LOAD, 1'b0, 0, -1);
  endtask

  task automatic test_load_store_both();
    run_instr("load_store_both", K_LOAD, 1'b1, 0, -1);
  endtask

  task automatic test_store();
    run_instr("store", K_STORE, 1'b0, 0, -1);
    run_instr("store_b2b", K_STORE, 1'b0, 0, -1);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_alu", K_ALU, 1'b0, 0, -1);
    run_instr("b2b_load", K_LOAD, 1'b0, 0, -1);
    run_instr("b2b_alu2", K_ALU, 1'b0, 0, -1);
  endtask

  task automatic test_run_drop();
    run_instr("run_drop_load", K_LOAD, 1'b0, 2, -1);
    idle("run_drop_idle", 3);
    run_instr("run_restart", K_ALU, 1'b0, 0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      idle("rand_idle", int'($urandom_range(0, 2)));
      run_instr("rand_instr", int'($urandom_range(0, 2)), 1'($urandom), 1, -1);
    end
  endtask

  task automatic test_reset_mid_mem();
    run_instr("pre_abort", K_ALU, 1'b0, 0, -1);
    run_instr("abort_load", K_LOAD, 1'b0, 0, 1);
    idle("post_abort", 3);
    run_instr("post_abort_alu", K_ALU, 1'b0, 0, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_defaults();
    test_reset();
    test_load();
    test_load_store_both();
    test_store();
    test_back_to_back();
    test_run_drop();
    test_random();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
